// File: rtl/short_preamble_detector.sv
// 802.11 short-training-field detector: delay-DELAY autocorrelation with WIN_LEN moving sums, gated by the power trigger.
// Define SHORT_PREAMBLE_TIMEOUT_EN to abandon a search after SEARCH_TIMEOUT stage-4 valid beats (FAIL state).
module short_preamble_detector #(
    parameter int DELAY          = 16,
    parameter int WIN_LEN        = 48,
    parameter int THRESH_Q3      = 6,
    parameter int MIN_PLATEAU    = 100,
    parameter int SEARCH_TIMEOUT = 400
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [31:0] sample_in,
    input  logic        sample_valid_in,
    input  logic        trigger_in,
    output logic        detected_out,
    output logic        searching_out
);

    localparam int AW         = 33 + $clog2(WIN_LEN);
    localparam int CW         = AW + 4;
    localparam int FILL_BEATS = DELAY + WIN_LEN;
    localparam int FW         = $clog2(FILL_BEATS + 1);
    localparam int RW         = $clog2(MIN_PLATEAU + 1);

    localparam logic [FW-1:0] FILL_MAX  = FW'(FILL_BEATS);
    localparam logic [FW-1:0] FILL_LAST = FW'(FILL_BEATS - 1);
    localparam logic [RW-1:0] RUN_LAST  = RW'(MIN_PLATEAU - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;
`ifdef SHORT_PREAMBLE_TIMEOUT_EN
    localparam logic [1:0] ST_FAIL   = 2'd3;
    localparam int         TW        = $clog2(SEARCH_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(SEARCH_TIMEOUT - 1);
`endif

    if (DELAY < 1 || WIN_LEN < 2 || MIN_PLATEAU < 1 || SEARCH_TIMEOUT < 1 ||
        THRESH_Q3 < 0 || THRESH_Q3 > 15) begin : g_bad_params
        $error("short_preamble_detector: parameter out of range");
    end

    // ---------------- stage 1: sample delay line, x[n] and x[n-DELAY] ----------------
    logic [31:0]   x_dl [DELAY];
    logic [31:0]   s1_cur;
    logic [31:0]   s1_old;
    logic          s1_valid;
    logic          s1_full;
    logic [FW-1:0] fill_cnt;

    // NOTE: the delay lines are reset like any other state so a restarted search never
    // correlates against samples from before the reset.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int k = 0; k < DELAY; k++) x_dl[k] <= '0;
            s1_cur   <= '0;
            s1_old   <= '0;
            s1_valid <= 1'b0;
            s1_full  <= 1'b0;
            fill_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments let every register see pre-edge values,
            // which is what makes the shift chain a chain rather than a single copy.
            s1_valid <= sample_valid_in;
            if (sample_valid_in) begin
                x_dl[0] <= sample_in;
                for (int k = 1; k < DELAY; k++) x_dl[k] <= x_dl[k-1];
                s1_cur  <= sample_in;
                s1_old  <= x_dl[DELAY-1];
                s1_full <= (fill_cnt >= FILL_LAST);
                if (fill_cnt != FILL_MAX) fill_cnt <= fill_cnt + FW'(1);
            end
        end
    end

    // ---------------- stage 2: per-sample correlation and power terms ----------------
    logic signed [15:0] i_c, q_c, i_d, q_d;
    logic signed [31:0] m_ii, m_qq, m_qi, m_iq, m_pi, m_pq;
    logic signed [32:0] cr_c, ci_c;
    logic        [32:0] p_c;

    assign i_c  = $signed(s1_cur[31:16]);
    assign q_c  = $signed(s1_cur[15:0]);
    assign i_d  = $signed(s1_old[31:16]);
    assign q_d  = $signed(s1_old[15:0]);

    assign m_ii = 32'(i_c) * 32'(i_d);
    assign m_qq = 32'(q_c) * 32'(q_d);
    assign m_qi = 32'(q_c) * 32'(i_d);
    assign m_iq = 32'(i_c) * 32'(q_d);
    assign m_pi = 32'(i_c) * 32'(i_c);
    assign m_pq = 32'(q_c) * 32'(q_c);

    assign cr_c = 33'(m_ii) + 33'(m_qq);
    assign ci_c = 33'(m_qi) - 33'(m_iq);
    assign p_c  = 33'(m_pi) + 33'(m_pq);

    logic signed [32:0] s2_cr, s2_ci;
    logic        [32:0] s2_p;
    logic               s2_valid;
    logic               s2_full;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s2_cr    <= '0;
            s2_ci    <= '0;
            s2_p     <= '0;
            s2_valid <= 1'b0;
            s2_full  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_cr   <= cr_c;
                s2_ci   <= ci_c;
                s2_p    <= p_c;
                s2_full <= s1_full;
            end
        end
    end

    // ---------------- stage 3: WIN_LEN moving sums ----------------
    logic signed [32:0] cr_dl [WIN_LEN];
    logic signed [32:0] ci_dl [WIN_LEN];
    logic        [32:0] p_dl  [WIN_LEN];
    logic signed [AW-1:0] sum_cr, sum_ci;
    logic        [AW-1:0] sum_p;
    logic                 s3_valid;
    logic                 s3_full;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int k = 0; k < WIN_LEN; k++) begin
                cr_dl[k] <= '0;
                ci_dl[k] <= '0;
                p_dl[k]  <= '0;
            end
            sum_cr   <= '0;
            sum_ci   <= '0;
            sum_p    <= '0;
            s3_valid <= 1'b0;
            s3_full  <= 1'b0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                cr_dl[0] <= s2_cr;
                ci_dl[0] <= s2_ci;
                p_dl[0]  <= s2_p;
                for (int k = 1; k < WIN_LEN; k++) begin
                    cr_dl[k] <= cr_dl[k-1];
                    ci_dl[k] <= ci_dl[k-1];
                    p_dl[k]  <= p_dl[k-1];
                end
                sum_cr  <= sum_cr + AW'(s2_cr) - AW'(cr_dl[WIN_LEN-1]);
                sum_ci  <= sum_ci + AW'(s2_ci) - AW'(ci_dl[WIN_LEN-1]);
                sum_p   <= sum_p  + AW'(s2_p)  - AW'(p_dl[WIN_LEN-1]);
                s3_full <= s2_full;
            end
        end
    end

    // ---------------- stage 4: |C| approximation and threshold ----------------
    logic [AW-1:0] abs_cr, abs_ci, mx, mn;
    logic [AW:0]   mag;
    logic [CW-1:0] lhs, rhs;

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        abs_cr = sum_cr[AW-1] ? AW'(-sum_cr) : AW'(sum_cr);
        abs_ci = sum_ci[AW-1] ? AW'(-sum_ci) : AW'(sum_ci);
        mx     = (abs_cr >= abs_ci) ? abs_cr : abs_ci;
        mn     = (abs_cr >= abs_ci) ? abs_ci : abs_cr;
        mag    = {1'b0, mx} + (AW+1)'(mn >> 1);
        lhs    = {mag, 3'b000};
        rhs    = {4'b0000, sum_p} * CW'(THRESH_Q3);
    end

    logic s4_valid;
    logic s4_pass;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s4_valid <= 1'b0;
            s4_pass  <= 1'b0;
        end else begin
            s4_valid <= s3_valid;
            s4_pass  <= s3_valid && s3_full && (lhs > rhs) && (sum_p != '0);
        end
    end

    // ---------------- control FSM (trigger_in is not pipelined) ----------------
    logic [1:0]    state;
    logic [RW-1:0] run;
`ifdef SHORT_PREAMBLE_TIMEOUT_EN
    logic [TW-1:0] tmo;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= ST_IDLE;
            run          <= '0;
            detected_out <= 1'b0;
`ifdef SHORT_PREAMBLE_TIMEOUT_EN
            tmo          <= '0;
`endif
        end else begin
            detected_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (trigger_in) begin
                        state <= ST_SEARCH;
                        run   <= '0;
`ifdef SHORT_PREAMBLE_TIMEOUT_EN
                        tmo   <= '0;
`endif
                    end
                end
                ST_SEARCH: begin
                    // Losing the trigger wins over a run completing in the same cycle.
                    if (!trigger_in) begin
                        state <= ST_IDLE;
                    end else if (s4_valid) begin
                        if (s4_pass && run == RUN_LAST) begin
                            detected_out <= 1'b1;
                            state        <= ST_LOCKED;
                        end else begin
                            run <= s4_pass ? run + RW'(1) : '0;
`ifdef SHORT_PREAMBLE_TIMEOUT_EN
                            if (tmo == TMO_LAST) state <= ST_FAIL;
                            else                 tmo   <= tmo + TW'(1);
`endif
                        end
                    end
                end
                ST_LOCKED: begin
                    if (!trigger_in) state <= ST_IDLE;
                end
`ifdef SHORT_PREAMBLE_TIMEOUT_EN
                ST_FAIL: begin
                    if (!trigger_in) state <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign searching_out = (state == ST_SEARCH);

endmodule
